wb_biquad_coeff_loader: RTL and testbench

Wishbone master that configures the biquad filter chain. On a load request it burst-reads NUM_WORDS 64-bit coefficient words from the coefficient BRAM into the biquad's shadow coefficient bank, then commits the bank with a swap pulse at the next sample boundary. The swap is timed so that a filter computation never runs on a partially loaded coefficient set. It sits between the coefficient BRAM wishbone slave and the biquad datapath. It is the source of done_loading.

---
 rtl/wb_biquad_coeff_loader.sv | 190 +++++++++++++++++++
 tb/tb_wb_biquad_coeff_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_biquad_coeff_loader.sv
// Wishbone coefficient loader for the biquad chain.
// Burst-reads NUM_WORDS words from the coefficient BRAM into the biquad
// shadow bank, then commits the bank with a one-cycle swap pulse on a
// sample boundary so no filter computation sees a half-loaded set.
// Optional feature macro: COEFF_LOADER_TIMEOUT_EN (ack watchdog + load_error).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer; waiting for a load request
// REQ       | wishbone burst active, one shadow write per ack
// WAIT_SWAP | bank fully written; waiting for sample_strobe, then swap
module wb_biquad_coeff_loader #(
    parameter int ADR_W          = 9,
    parameter int DAT_W          = 64,
    parameter int NUM_WORDS      = 10,
    parameter int BASE_ADR       = 0,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             load_new_coefficients,
    input  logic             sample_strobe,
    output logic             coeff_wbm_cyc_o,
    output logic             coeff_wbm_stb_o,
    output logic [ADR_W-1:0] coeff_wbm_adr_o,
    input  logic [DAT_W-1:0] coeff_wbm_dat_i,
    input  logic             coeff_wbm_ack_i,
    output logic             coeff_wr_en,
    output logic [IDX_W-1:0] coeff_wr_idx,
    output logic [DAT_W-1:0] coeff_wr_dat,
    output logic             coeff_swap,
    output logic             done_loading,
    output logic             busy,
    output logic             load_error
);

    localparam logic [ADR_W-1:0] BASE     = ADR_W'(BASE_ADR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // Reject parameter sets the index counter or watchdog cannot represent.
    if (NUM_WORDS < 2 || (2 ** IDX_W) < NUM_WORDS || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("wb_biquad_coeff_loader: invalid parameter combination");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT_SWAP} state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [DAT_W-1:0]   wr_dat_q, wr_dat_d;
    logic               swap_q, swap_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               start;

`ifdef COEFF_LOADER_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    // Register every output and all control state; reset releases to IDLE.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            adr_q    <= BASE;
            cnt_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
            wr_dat_q <= '0;
            swap_q   <= 1'b0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef COEFF_LOADER_TIMEOUT_EN
            wd_q     <= WD_RELOAD;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= wr_en_d;
            wr_idx_q <= wr_idx_d;
            wr_dat_q <= wr_dat_d;
            swap_q   <= swap_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
`ifdef COEFF_LOADER_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state and next-output logic. The swap cycle itself is spent in
    // WAIT_SWAP so a request arriving there still counts as pending.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        wr_en_d  = 1'b0;
        wr_idx_d = wr_idx_q;
        wr_dat_d = wr_dat_q;
        swap_d   = 1'b0;
        pend_d   = pend_q;
        start    = 1'b0;
`ifdef COEFF_LOADER_TIMEOUT_EN
        wd_d     = wd_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load_new_coefficients) start = 1'b1;
            end
            REQ: begin
                if (load_new_coefficients) pend_d = 1'b1;
                if (coeff_wbm_ack_i) begin
                    wr_en_d  = 1'b1;
                    wr_idx_d = cnt_q;
                    wr_dat_d = coeff_wbm_dat_i;
`ifdef COEFF_LOADER_TIMEOUT_EN
                    wd_d     = WD_RELOAD;
`endif
                    if (cnt_q == LAST_IDX) begin
                        cyc_d   = 1'b0;
                        state_d = WAIT_SWAP;
                    end else begin
                        adr_d = adr_q + 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef COEFF_LOADER_TIMEOUT_EN
                else if (wd_q == '0) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
`endif
            end
            WAIT_SWAP: begin
                if (load_new_coefficients) pend_d = 1'b1;
                if (swap_q) begin
                    if (pend_d) start = 1'b1;
                    else        state_d = IDLE;
                end else if (sample_strobe) begin
                    swap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = REQ;
            cyc_d   = 1'b1;
            adr_d   = BASE;
            cnt_d   = '0;
            pend_d  = 1'b0;
`ifdef COEFF_LOADER_TIMEOUT_EN
            wd_d    = WD_RELOAD;
`endif
        end
        busy_d = (state_d != IDLE);
    end

    assign coeff_wbm_cyc_o = cyc_q;
    assign coeff_wbm_stb_o = cyc_q;
    assign coeff_wbm_adr_o = adr_q;
    assign coeff_wr_en     = wr_en_q;
    assign coeff_wr_idx    = wr_idx_q;
    assign coeff_wr_dat    = wr_dat_q;
    assign coeff_swap      = swap_q;
    assign done_loading    = swap_q;
    assign busy            = busy_q;
`ifdef COEFF_LOADER_TIMEOUT_EN
    assign load_error      = err_q;
`else
    assign load_error      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_biquad_coeff_loader.sv
// Scoreboard bench for wb_biquad_coeff_loader: stimulus pushes expected
// addresses, shadow writes and committed banks; a negedge monitor pops and
// compares whatever the DUT presents.
module tb_wb_biquad_coeff_loader;

    localparam int NW   = 10;
    localparam int BASE = 0;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        sample_strobe = 1'b0;
    logic        cyc, stb, ack;
    logic [8:0]  adr;
    logic [63:0] dat;
    logic        wr_en, swap, done, busy, lerr;
    logic [3:0]  wr_idx;
    logic [63:0] wr_dat;

    logic [63:0] mem [0:511];
    int          waits = 0;
    int          wcnt = 0;
    logic        hang = 1'b0;
    logic        stray_ack = 1'b0;
    logic        strobe_hi = 1'b0;
    int          strobe_per = 8;
    int          strobe_cnt = 0;

    int checks = 0, errors = 0;
    int cyc_n = 0;
    int wr_total = 0, swap_total = 0, err_total = 0, rise_total = 0;
    int last_wr_cyc = 0, swap_cyc = 0, last_ack_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    int req_cyc = 0;
    logic cyc_prev = 1'b0, strobe_prev = 1'b0;

    int          exp_adr [$];
    int          exp_idx [$];
    logic [63:0] exp_dat [$];
    logic [63:0] exp_bank [$];
    logic [63:0] shadow [0:15];

    wb_biquad_coeff_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .load_new_coefficients(load), .sample_strobe(sample_strobe),
        .coeff_wbm_cyc_o(cyc), .coeff_wbm_stb_o(stb), .coeff_wbm_adr_o(adr),
        .coeff_wbm_dat_i(dat), .coeff_wbm_ack_i(ack),
        .coeff_wr_en(wr_en), .coeff_wr_idx(wr_idx), .coeff_wr_dat(wr_dat),
        .coeff_swap(swap), .done_loading(done), .busy(busy), .load_error(lerr)
    );

    always #5 clk = ~clk;

    // BRAM slave model with programmable wait states and a "never ack word 3" mode.
    assign dat = mem[adr];
    assign ack = stray_ack | (cyc & stb & (wcnt == waits) & ~(hang & (adr == 9'd3)));
    always @(posedge clk) begin
        cyc_n = cyc_n + 1;
        if (cyc && stb && !ack) wcnt <= wcnt + 1;
        else                    wcnt <= 0;
    end

    // Sample-boundary generator: periodic or held high.
    initial forever begin
        @(posedge clk); #1;
        strobe_cnt = (strobe_cnt + 1) % strobe_per;
        sample_strobe = strobe_hi || (strobe_cnt == 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: a load of n words reads BASE+k (mod 512) into index k.
    task automatic push_load(input int n, input bit full);
        for (int k = 0; k < n; k++) begin
            exp_adr.push_back((BASE + k) % 512);
            exp_idx.push_back(k);
            exp_dat.push_back(mem[(BASE + k) % 512]);
            if (full) exp_bank.push_back(mem[(BASE + k) % 512]);
        end
    endtask

    task automatic flush_sb();
        exp_adr.delete(); exp_idx.delete(); exp_dat.delete(); exp_bank.delete();
    endtask

    task automatic pulse_load();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        req_cyc = cyc_n;
    endtask

    task automatic wait_swaps(input int target, input int bound);
        int n = 0;
        while (swap_total < target && n < bound) begin @(posedge clk); n++; end
        chk("swap_wait", swap_total >= target, 1);
    endtask

    task automatic wait_wr(input int target, input int bound);
        int n = 0;
        while (wr_total < target && n < bound) begin @(posedge clk); n++; end
        chk("wr_wait", wr_total >= target, 1);
    endtask

    // Monitor: pops the scoreboard on every address phase, write and swap.
    always @(negedge clk) begin
        if (!rst) begin
            if (cyc && stb && ack) begin
                last_ack_cyc = cyc_n + 1;
                chk("adr_expected", exp_adr.size() != 0, 1);
                if (exp_adr.size() != 0) chk("adr", 64'(adr), 64'(exp_adr.pop_front()));
            end
            if (wr_en) begin
                chk("wr_expected", exp_idx.size() != 0, 1);
                if (exp_idx.size() != 0) begin
                    chk("wr_idx", 64'(wr_idx), 64'(exp_idx.pop_front()));
                    chk("wr_dat", wr_dat, exp_dat.pop_front());
                end
                shadow[wr_idx] = wr_dat;
                wr_total++;
                last_wr_cyc = cyc_n;
            end
            if (swap || done) chk("done_eq_swap", 64'(done), 64'(swap));
            if (swap) begin
                bit ok = 1'b1;
                chk("swap_not_with_wr", 64'(wr_en), 0);
                chk("swap_on_strobe", 64'(strobe_prev), 1);
                chk("cyc_at_swap", 64'(cyc), 0);
                chk("bank_expected", exp_bank.size() >= NW, 1);
                if (exp_bank.size() >= NW)
                    for (int k = 0; k < NW; k++)
                        if (shadow[k] !== exp_bank.pop_front()) ok = 1'b0;
                chk("bank_content", 64'(ok), 1);
                swap_total++;
                swap_cyc = cyc_n;
            end
            if (lerr) err_total++;
            if (cyc && !cyc_prev) begin rise_total++; rise_cyc = cyc_n; end
            if (!cyc && cyc_prev) fall_cyc = cyc_n;
        end
        cyc_prev    = cyc;
        strobe_prev = sample_strobe;
    end

    initial begin
        int s0, d0, r0, w0, s1;
        for (int k = 0; k < 512; k++) mem[k] = 64'hDDDDDDDD_EEEE0000 + 64'(k);
        for (int k = 0; k < 16; k++) shadow[k] = '0;

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 64'(cyc), 0);
        chk("rst_stb", 64'(stb), 0);
        chk("rst_adr", 64'(adr), BASE);
        chk("rst_outs", {wr_en, swap, done, busy, lerr}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 0);

        // 1: auto-ack burst, strobe every 8 cycles
        push_load(NW, 1);
        pulse_load();
        @(negedge clk);
        chk("t1_first_cyc", {cyc, stb}, 2'b11);
        wait_swaps(1, 200);
        chk("t1_last_wr_lat", 64'(last_wr_cyc - req_cyc + 1), NW + 1);
        repeat (3) @(negedge clk);
        chk("t1_busy_after", 64'(busy), 0);
        chk("t1_swaps", 64'(swap_total), 1);

        // Ack outside REQ is ignored
        w0 = wr_total;
        @(posedge clk); #1 stray_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1 stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_no_wr", 64'(wr_total), 64'(w0));

        // 2: two wait states per word
        waits = 2;
        push_load(NW, 1);
        pulse_load();
        wait_swaps(2, 300);
        chk("t2_last_wr_lat", 64'(last_wr_cyc - req_cyc + 1), 3 * NW + 1);
        waits = 0;

        // 3: extra requests mid-burst collapse into exactly one reload
        s0 = swap_total; r0 = rise_total; w0 = wr_total;
        push_load(NW, 1);
        pulse_load();
        repeat (2) @(posedge clk);
        pulse_load();
        pulse_load();
        wait_wr(w0 + NW, 100);
        for (int k = 0; k < NW; k++) mem[k] = 64'hBBBBBBBB_CCCCCCCC;
        push_load(NW, 1);
        wait_swaps(s0 + 1, 100);
        s1 = swap_cyc;
        wait_swaps(s0 + 2, 200);
        repeat (20) @(negedge clk);
        chk("t3_done_pulses", 64'(swap_total - s0), 2);
        chk("t3_bursts", 64'(rise_total - r0), 2);
        chk("t3_reload_start", 64'(rise_cyc), 64'(s1 + 1));
        chk("t3_shadow_new", shadow[NW-1], 64'hBBBBBBBB_CCCCCCCC);

        // 4: reset at word 5 drops the bus at once, no commit
        for (int k = 0; k < NW; k++) mem[k] = 64'h1234_0000_0000_0000 + 64'(k * 7);
        s0 = swap_total; w0 = wr_total;
        push_load(NW, 1);
        pulse_load();
        wait_wr(w0 + 5, 100);
        #2 rst = 1'b1;
        #1;
        chk("t4_async_drop", {cyc, stb, wr_en}, 0);
        flush_sb();
        repeat (12) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_no_swap", 64'(swap_total), 64'(s0));
        push_load(NW, 1);
        pulse_load();
        @(negedge clk);
        chk("t4_restart_adr", 64'(adr), BASE);
        wait_swaps(s0 + 1, 200);

        // 5: strobe held high -> swap one cycle after last write
        strobe_hi = 1'b1;
        s0 = swap_total;
        push_load(NW, 1);
        pulse_load();
        wait_swaps(s0 + 1, 100);
        chk("t5_swap_after_wr", 64'(swap_cyc - last_wr_cyc), 1);
        strobe_hi = 1'b0;

        // Randomized loads
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < NW; k++) mem[(BASE + k) % 512] = {$urandom, $urandom};
            waits      = $urandom_range(0, 3);
            strobe_per = $urandom_range(2, 12);
            strobe_hi  = ($urandom_range(0, 3) == 0);
            s0 = swap_total;
            push_load(NW, 1);
            pulse_load();
            wait_swaps(s0 + 1, 400);
            chk("rnd_last_wr_lat", 64'(last_wr_cyc - req_cyc + 1), 64'(NW * (waits + 1) + 1));
            repeat (3) @(negedge clk);
            chk("rnd_busy_after", 64'(busy), 0);
        end
        waits = 0; strobe_hi = 1'b0; strobe_per = 8;

        // 6: slave never acks word 3
        s0 = swap_total; d0 = err_total; w0 = wr_total;
        hang = 1'b1;
        push_load(3, 0);
        pulse_load();
`ifdef COEFF_LOADER_TIMEOUT_EN
        begin
            int n = 0;
            @(negedge clk);
            while (cyc && n < 100) begin @(negedge clk); n++; end
        end
        chk("t6_cyc_dropped", 64'(cyc), 0);
        chk("t6_abort_delay", 64'(fall_cyc - last_ack_cyc), TMO);
        repeat (20) @(negedge clk);
        chk("t6_one_error", 64'(err_total - d0), 1);
        chk("t6_no_swap", 64'(swap_total), 64'(s0));
        chk("t6_busy", 64'(busy), 0);
`else
        repeat (60) @(negedge clk);
        chk("t6_cyc_held", {cyc, stb}, 2'b11);
        chk("t6_no_error", 64'(err_total), 64'(d0));
        chk("t6_words_before_hang", 64'(wr_total - w0), 3);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
`endif
        hang = 1'b0;
        flush_sb();

        // Recovery load after the stalled transfer
        s0 = swap_total;
        push_load(NW, 1);
        pulse_load();
        wait_swaps(s0 + 1, 200);
        repeat (3) @(negedge clk);
        chk("final_queues_empty", 64'(exp_adr.size() + exp_idx.size() + exp_bank.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
